// File: rtl/edge_channel_arbiter.sv
// edge_channel_arbiter
// Shares one RTI_Core input FIFO between NUM_CH edge-counter channels.
// Each channel owns a one-deep holding register. Held words are drained
// round-robin at one word per cycle while the FIFO has room, and each word
// carries its source channel number in the top CH_ID_W bits. A write that
// arrives while the channel's register is still occupied is dropped. Each
// drop sets a sticky per-channel flag and advances a saturating counter.
module edge_channel_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int CH_ID_W    = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_write,
  input  logic [NUM_CH*128-1:0]   ch_din,
  input  logic                    fifo_full,
  output logic                    fifo_write,
  output logic [127:0]            fifo_din,
  output logic [NUM_CH-1:0]       ch_pending,
  input  logic                    clear_drop,
  output logic [NUM_CH-1:0]       drop_flag,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  // Width of a channel index. NUM_CH is at least 2, so this is never 0.
  localparam int IDX_W = $clog2(NUM_CH);

  // Holds up to 2*NUM_CH-1, the largest value reached while the search
  // wraps around.
  localparam int CAND_W = IDX_W + 1;
  localparam logic [CAND_W-1:0] NUM_CH_C = CAND_W'(NUM_CH);

  // Per-cycle drop total. 5 bits hold the worst case of 16 channels.
  localparam int NDROP_W = 5;
  localparam int EXT_W   = DROP_CNT_W + NDROP_W;
  localparam logic [EXT_W-1:0] DROP_MAX_EXT = {{NDROP_W{1'b0}}, {DROP_CNT_W{1'b1}}};

  // Channel registers.
  logic [NUM_CH-1:0] pend_reg;
  logic [127:0]      hold_reg [NUM_CH];
  logic [IDX_W-1:0]  last_reg;
  logic [NUM_CH-1:0] drop_flag_reg;
  logic [DROP_CNT_W-1:0] drop_count_reg;

  // Grant path.
  logic [NUM_CH-1:0] req;
  logic              grant_valid;
  logic [IDX_W-1:0]  winner;
  logic [NUM_CH-1:0] collide;
  logic [NUM_CH-1:0] granted;

  // Drop accounting.
  logic [NDROP_W-1:0]    n_drop;
  logic [EXT_W-1:0]      drop_sum;
  logic [NUM_CH-1:0]     drop_flag_next;
  logic [DROP_CNT_W-1:0] drop_count_next;

  // Requests are masked while reset is high. Without this mask, words still
  // held from before reset would be written to the FIFO during the reset
  // cycle itself.
  assign req = pend_reg & {NUM_CH{enable & ~fifo_full & ~reset}};

  // Rotating-priority search: take the first request found, starting at
  // last_reg+1 and wrapping modulo NUM_CH.
  always_comb begin
    logic [CAND_W-1:0] cand;
    logic [IDX_W-1:0]  idx;
    grant_valid = 1'b0;
    winner      = '0;
    cand        = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, last_reg} + CAND_W'(k);
      if (cand >= NUM_CH_C) begin
        cand = cand - NUM_CH_C;
      end
      idx = cand[IDX_W-1:0];
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        winner      = idx;
      end
    end
  end

  // The FIFO word is the channel tag followed by the low payload bits.
  // The top CH_ID_W bits of the held word are discarded.
  always_comb begin
    logic [CH_ID_W-1:0] tag;
    tag = CH_ID_W'(winner);
    fifo_din = '0;
    if (grant_valid) begin
      fifo_din = {tag, hold_reg[winner][127-CH_ID_W:0]};
    end
  end

  assign fifo_write = grant_valid;
  assign ch_pending = pend_reg;
  assign drop_flag  = drop_flag_reg;
  assign drop_count = drop_count_reg;

  // Per-channel holding register and pending bit.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic capture;

      assign granted[gi] = grant_valid && (winner == IDX_W'(gi));
      // A channel whose word leaves this cycle can take a new word on the
      // same edge. That is what lets a sole requester write every cycle.
      assign capture     = ch_write[gi] && (!pend_reg[gi] || granted[gi]);
      assign collide[gi] = ch_write[gi] && pend_reg[gi] && !granted[gi];

      // Load a new word on capture, otherwise release the register on grant.
      always_ff @(posedge clk) begin
        if (reset) begin
          pend_reg[gi] <= 1'b0;
          hold_reg[gi] <= '0;
        end else if (capture) begin
          pend_reg[gi] <= 1'b1;
          hold_reg[gi] <= ch_din[128*gi +: 128];
        end else if (granted[gi]) begin
          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Count this cycle's drops and add them to the cleared or current total,
  // saturating at all-ones. A collision in the same cycle as clear_drop
  // therefore survives the clear.
  always_comb begin
    logic [DROP_CNT_W-1:0] base;
    n_drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_drop = n_drop + NDROP_W'(collide[i]);
    end
    base     = clear_drop ? '0 : drop_count_reg;
    drop_sum = {{NDROP_W{1'b0}}, base} + {{DROP_CNT_W{1'b0}}, n_drop};
    if (drop_sum > DROP_MAX_EXT) begin
      drop_count_next = {DROP_CNT_W{1'b1}};
    end else begin
      drop_count_next = drop_sum[DROP_CNT_W-1:0];
    end
    drop_flag_next = (clear_drop ? '0 : drop_flag_reg) | collide;
  end

  // Drop accounting registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_flag_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      drop_flag_reg  <= drop_flag_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // The round-robin pointer moves only when a word is actually written.
  // A full FIFO therefore leaves the pointer where it is. After reset,
  // channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= IDX_W'(NUM_CH - 1);
    end else if (grant_valid) begin
      last_reg <= winner;
    end
  end

endmodule

// File: tb/tb_edge_channel_arbiter.sv
// Directed testbench for edge_channel_arbiter (4 channels, 8-bit tag,
// 4-bit drop counter). Inputs change 1 ns after the rising edge. Outputs
// are compared at the falling edge.
module tb_edge_channel_arbiter;

  localparam int NUM_CH     = 4;
  localparam int CH_ID_W    = 8;
  localparam int DROP_CNT_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  enable;
  logic [NUM_CH-1:0]     ch_write;
  logic [NUM_CH*128-1:0] ch_din;
  logic                  fifo_full;
  logic                  fifo_write;
  logic [127:0]          fifo_din;
  logic [NUM_CH-1:0]     ch_pending;
  logic                  clear_drop;
  logic [NUM_CH-1:0]     drop_flag;
  logic [DROP_CNT_W-1:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  edge_channel_arbiter #(
    .NUM_CH(NUM_CH), .CH_ID_W(CH_ID_W), .DROP_CNT_W(DROP_CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_write(ch_write),
    .ch_din(ch_din), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_din(fifo_din), .ch_pending(ch_pending), .clear_drop(clear_drop),
    .drop_flag(drop_flag), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait from the drive point to the falling edge.
  task automatic settle();
    #4;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; ch_write = '0; ch_din = '0;
    fifo_full = 1'b0; clear_drop = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_checks++;
    if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_write: got %b expected 0", fifo_write); end
    n_checks++;
    if (fifo_din !== 128'h0) begin n_fail++; $display("FAIL reset_fifo_din: got %h expected 0", fifo_din); end
    n_checks++;
    if (ch_pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", ch_pending); end
    n_checks++;
    if (drop_flag !== 4'b0000 || drop_count !== 4'h0) begin
      n_fail++; $display("FAIL reset_drop: got flag=%b count=%h expected 0000/0", drop_flag, drop_count);
    end
    $display("txn reset: fifo_write=%b pending=%b", fifo_write, ch_pending);
  endtask

  task automatic test_single();
    do_reset();
    ch_write = 4'b0100;
    ch_din[128*2 +: 128] = 128'h1234;
    step();
    ch_write = '0;
    settle();
    n_checks++;
    if (fifo_write !== 1'b1) begin n_fail++; $display("FAIL single_write: got %b expected 1", fifo_write); end
    n_checks++;
    if (fifo_din !== {8'h02, 120'h1234}) begin n_fail++; $display("FAIL single_din: got %h expected %h", fifo_din, {8'h02, 120'h1234}); end
    $display("txn single: fifo_din=%h", fifo_din);
    step();
    settle();
    n_checks++;
    if (ch_pending !== 4'b0000 || fifo_write !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got pending=%b write=%b expected 0000/0", ch_pending, fifo_write);
    end
  endtask

  task automatic test_contention();
    logic [127:0] exp;
    do_reset();
    ch_write = 4'b1111;
    for (int i = 0; i < NUM_CH; i++) ch_din[128*i +: 128] = 128'hA000 + 128'(i);
    step();
    ch_write = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      settle();
      exp = {8'(c), 120'hA000 + 120'(c)};
      n_checks++;
      if (fifo_write !== 1'b1 || fifo_din !== exp) begin
        n_fail++; $display("FAIL contention_ch%0d: got write=%b din=%h expected 1/%h", c, fifo_write, fifo_din, exp);
      end
      $display("txn contention: cycle %0d din=%h", c, fifo_din);
      step();
    end
    settle();
    n_checks++;
    if (ch_pending !== 4'b0000 || drop_count !== 4'h0 || fifo_write !== 1'b0) begin
      n_fail++; $display("FAIL contention_end: got pending=%b drops=%h write=%b expected 0000/0/0", ch_pending, drop_count, fifo_write);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    do_reset();
    ch_write = 4'b0001;
    ch_din[127:0] = 128'hD0;
    step();
    for (int c = 0; c < 3; c++) begin
      if (c < 2) ch_din[127:0] = 128'hD1 + 128'(c);
      else ch_write = '0;
      settle();
      exp = {8'h00, 120'hD0 + 120'(c)};
      n_checks++;
      if (fifo_write !== 1'b1 || fifo_din !== exp) begin
        n_fail++; $display("FAIL b2b_word%0d: got write=%b din=%h expected 1/%h", c, fifo_write, fifo_din, exp);
      end
      $display("txn b2b: word %0d din=%h", c, fifo_din);
      step();
    end
    settle();
    n_checks++;
    if (fifo_write !== 1'b0 || drop_count !== 4'h0 || drop_flag !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_end: got write=%b drops=%h flag=%b expected 0/0/0000", fifo_write, drop_count, drop_flag);
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    ch_write = 4'b0110;
    ch_din[128*1 +: 128] = 128'hE1;
    ch_din[128*2 +: 128] = 128'hE2;
    step();
    ch_write = '0;
    settle();
    n_checks++;
    if (fifo_write !== 1'b0 || ch_pending !== 4'b0110) begin
      n_fail++; $display("FAIL enable_hold: got write=%b pending=%b expected 0/0110", fifo_write, ch_pending);
    end
    step();
    enable = 1'b1;
    settle();
    n_checks++;
    if (fifo_din !== {8'h01, 120'hE1}) begin n_fail++; $display("FAIL enable_first: got %h expected %h", fifo_din, {8'h01, 120'hE1}); end
    step();
    settle();
    n_checks++;
    if (fifo_din !== {8'h02, 120'hE2}) begin n_fail++; $display("FAIL enable_second: got %h expected %h", fifo_din, {8'h02, 120'hE2}); end
    $display("txn enable: second din=%h", fifo_din);
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    fifo_full = 1'b1;
    ch_write = 4'b0010;
    ch_din[128*1 +: 128] = 128'h1111;
    step();
    ch_write = '0;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_checks++;
      if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL bp_nowrite%0d: got %b expected 0", c, fifo_write); end
      step();
    end
    ch_write = 4'b0010;
    ch_din[128*1 +: 128] = 128'h2222;
    step();
    ch_write = '0;
    settle();
    n_checks++;
    if (fifo_write !== 1'b0 || drop_flag !== 4'b0010 || drop_count !== 4'h1) begin
      n_fail++; $display("FAIL bp_collision: got write=%b flag=%b count=%h expected 0/0010/1", fifo_write, drop_flag, drop_count);
    end
    step();
    fifo_full = 1'b0;
    settle();
    n_checks++;
    if (fifo_write !== 1'b1 || fifo_din !== {8'h01, 120'h1111}) begin
      n_fail++; $display("FAIL bp_release: got write=%b din=%h expected 1/%h", fifo_write, fifo_din, {8'h01, 120'h1111});
    end
    $display("txn backpressure: released din=%h", fifo_din);
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    fifo_full = 1'b1;
    ch_write = 4'b0001;
    step();
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 14) begin
        settle();
        n_checks++;
        if (drop_count !== 4'hE) begin n_fail++; $display("FAIL sat_mid: got %h expected e", drop_count); end
      end
    end
    ch_write = '0;
    settle();
    n_checks++;
    if (drop_count !== 4'hF || drop_flag !== 4'b0001) begin
      n_fail++; $display("FAIL sat_final: got count=%h flag=%b expected f/0001", drop_count, drop_flag);
    end
    $display("txn saturation: drop_count=%h", drop_count);
  endtask

  task automatic test_clear_vs_collision();
    // Continues from the saturation state: FIFO full, ch0 pending, count=F.
    step();
    ch_write = 4'b1000;
    step();
    clear_drop = 1'b1;
    step();
    ch_write = '0;
    clear_drop = 1'b0;
    settle();
    n_checks++;
    if (drop_flag !== 4'b1000 || drop_count !== 4'h1) begin
      n_fail++; $display("FAIL clear_vs_collision: got flag=%b count=%h expected 1000/1", drop_flag, drop_count);
    end
    step();
    clear_drop = 1'b1;
    step();
    clear_drop = 1'b0;
    settle();
    n_checks++;
    if (drop_flag !== 4'b0000 || drop_count !== 4'h0) begin
      n_fail++; $display("FAIL clear_only: got flag=%b count=%h expected 0000/0", drop_flag, drop_count);
    end
    $display("txn clear: flag=%b count=%h", drop_flag, drop_count);
  endtask

  task automatic test_reset_mid();
    do_reset();
    fifo_full = 1'b1;
    ch_write = 4'b0011;
    ch_din[127:0] = 128'h55;
    ch_din[128*1 +: 128] = 128'h66;
    step();
    ch_write = '0;
    settle();
    n_checks++;
    if (ch_pending !== 4'b0011) begin n_fail++; $display("FAIL rmid_pending: got %b expected 0011", ch_pending); end
    step();
    fifo_full = 1'b0;
    reset = 1'b1;
    settle();
    n_checks++;
    if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL rmid_reset_cycle: got %b expected 0", fifo_write); end
    step();
    reset = 1'b0;
    settle();
    n_checks++;
    if (fifo_write !== 1'b0 || fifo_din !== 128'h0 || ch_pending !== 4'b0000 ||
        drop_flag !== 4'b0000 || drop_count !== 4'h0) begin
      n_fail++; $display("FAIL rmid_after: got write=%b din=%h pending=%b flag=%b count=%h expected all zero",
                         fifo_write, fifo_din, ch_pending, drop_flag, drop_count);
    end
    $display("txn reset_mid: pending=%b write=%b", ch_pending, fifo_write);
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_enable();
    test_backpressure();
    test_saturation();
    test_clear_vs_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
